// File: rtl/mips_isa_pkg.sv
// -----------------------------------------------------------------------------
// mips_isa_pkg
//   Shared MIPS subset definitions: mnemonic codes, primary opcodes and
//   R-type funct codes, plus helpers that assemble the three instruction
//   formats. The encoder uses this package, and the main/ALU control decoders
//   use it as well, so both directions of the mapping come from one table.
// -----------------------------------------------------------------------------
package mips_isa_pkg;

    // Symbolic mnemonics. Codes 12-15 are intentionally unassigned (illegal).
    typedef enum logic [3:0] {
        MN_ADD  = 4'd0,
        MN_SUB  = 4'd1,
        MN_AND  = 4'd2,
        MN_OR   = 4'd3,
        MN_SLT  = 4'd4,
        MN_J    = 4'd5,
        MN_BEQ  = 4'd6,
        MN_BNE  = 4'd7,
        MN_ADDI = 4'd8,
        MN_ORI  = 4'd9,
        MN_LW   = 4'd10,
        MN_SW   = 4'd11
    } mnemonic_e;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0]).
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // R-type: shamt is always zero in this subset.
    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [25:0] target);
        return {OP_J, target};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
//   Combinational packer: mnemonic plus operand fields -> 32-bit MIPS word.
//   Only the fields belonging to the selected format reach the word; the rest
//   are ignored so stale values on the bus cannot leak into the encoding.
//
// Ports
//   op_i      4   mnemonic code (12-15 illegal)
//   rs_i      5   rs field
//   rt_i      5   rt field
//   rd_i      5   rd field (R-type only)
//   imm_i     16  immediate/offset (I-type only)
//   target_i  26  jump target (J only)
//   word_o    32  encoded instruction (zero when illegal)
//   illegal_o 1   op_i is not a supported mnemonic
// -----------------------------------------------------------------------------
module instr_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_i)
            MN_ADD:  word_o = r_word(rs_i, rt_i, rd_i, F_ADD);
            MN_SUB:  word_o = r_word(rs_i, rt_i, rd_i, F_SUB);
            MN_AND:  word_o = r_word(rs_i, rt_i, rd_i, F_AND);
            MN_OR:   word_o = r_word(rs_i, rt_i, rd_i, F_OR);
            MN_SLT:  word_o = r_word(rs_i, rt_i, rd_i, F_SLT);
            MN_J:    word_o = j_word(target_i);
            MN_BEQ:  word_o = i_word(OP_BEQ, rs_i, rt_i, imm_i);
            MN_BNE:  word_o = i_word(OP_BNE, rs_i, rt_i, imm_i);
            MN_ADDI: word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
            MN_ORI:  word_o = i_word(OP_ORI, rs_i, rt_i, imm_i);
            MN_LW:   word_o = i_word(OP_LW, rs_i, rt_i, imm_i);
            MN_SW:   word_o = i_word(OP_SW, rs_i, rt_i, imm_i);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Streaming MIPS instruction encoder. Symbolic beats come in on a valid/ready
//   port, are packed by instr_pack and land in a single output register that is
//   presented with a sequential word address on a second valid/ready port.
//
//   Handshake rule (both ports): a transfer happens on a rising clock edge
//   where valid && ready are both high. The producer holds its payload stable
//   while valid is high and ready is low; ready may depend combinationally on
//   the consumer side (in_ready follows out_ready), valid never depends on ready.
//
// Ports
//   clk        1         clock, all state on rising edge
//   reset      1         asynchronous active-high reset
//   clear      1         synchronous restart (flush word, reload address, clear err/count)
//   in_valid   1         input beat valid
//   in_ready   1         encoder can accept a beat
//   in_op      4         mnemonic code
//   in_rs/rt/rd 5        register fields
//   in_imm     16        immediate/offset
//   in_target  26        jump target
//   out_valid  1         encoded word valid
//   out_ready  1         consumer accepts word
//   out_instr  32        encoded instruction
//   out_addr   ADDR_W    word address of out_instr
//   err        1         sticky illegal-mnemonic flag
//   count      ADDR_W+1  words emitted, saturating at 2^ADDR_W
// -----------------------------------------------------------------------------
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              err_q,   err_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [31:0] packed_word;
    logic        packed_illegal;
    logic        in_fire;
    logic        out_fire;

    instr_pack u_pack (
        .op_i      (in_op),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .imm_i     (in_imm),
        .target_i  (in_target),
        .word_o    (packed_word),
        .illegal_o (packed_illegal)
    );

    // The register can take a new word when empty or when its current word
    // leaves on this same edge. clear blocks input so nothing slips past a flush.
    assign in_ready = !clear && (!valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        err_d   = err_q;
        count_d = count_q;

        if (clear) begin
            valid_d = 1'b0;
            instr_d = '0;
            addr_d  = BASE;
            err_d   = 1'b0;
            count_d = '0;
        end else begin
            if (out_fire) begin
                valid_d = 1'b0;
                // Natural ADDR_W-bit overflow gives the mod-2^ADDR_W wrap.
                addr_d  = addr_q + 1'b1;
                if (count_q != COUNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
            end
            // An illegal beat is consumed but never occupies the output register,
            // so a word leaving on the same edge still drops out_valid.
            if (in_fire) begin
                if (packed_illegal) begin
                    err_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    instr_d = packed_word;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            addr_q  <= BASE;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule
